// File: rtl/ota_sd_pkg.sv
// ota_sd_pkg -- shared definitions for the OTA sigma-delta readout.
//   state_t      : controller states (IDLE, RUN, DONE)
//   OSR_LOG2_DEF : default log2 of the decimation window length
package ota_sd_pkg;

  localparam int OSR_LOG2_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ota_sd_readout_sync2.sv
// sync2 -- two-flop synchronizer for the asynchronous comparator input.
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset, clears both flops
//   d     : asynchronous input
//   q     : synchronized output (second flop)
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture; the first stage may go metastable, the second settles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/ota_sd_readout.sv
// ota_sd_readout -- digital half of a first-order OTA-based sigma-delta
// converter: closes the 1-bit feedback loop and decimates the bitstream by
// counting ones over a window of 2**OSR_LOG2 cycles.
//   clk, rst_n    : single clock, asynchronous active-low reset
//   en            : conversion enable
//   cmp_in        : asynchronous OTA output used as the comparator
//   fb_out        : registered 1-bit DAC feedback
//   chop_out      : chopper phase for the analog input switches
//   result        : decimated ones-count (CNT_W bits)
//   result_valid  : result available; result_ready accepts it
//   overrun       : sticky, an unaccepted result was overwritten
// Build option: define OTA_SD_CHOP_EN to enable chopping. The chopper phase
// then flips every window, the sample bit is demodulated with it, and the
// result is the saturating sum of the last two window counts.
module ota_sd_readout
  import ota_sd_pkg::*;
#(
  parameter int OSR_LOG2 = OSR_LOG2_DEF,
  parameter int CNT_W    = OSR_LOG2 + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cmp_in,
  output logic             fb_out,
  output logic             chop_out,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             overrun
);

  localparam logic [OSR_LOG2-1:0] WIN_LAST = {OSR_LOG2{1'b1}};
  localparam logic [OSR_LOG2-1:0] WIN_ONE  = {{(OSR_LOG2-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};

  // Unsigned add that clamps at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[CNT_W]) begin
      return CNT_MAX;
    end else begin
      return sum[CNT_W-1:0];
    end
  endfunction

  state_t              state_r;
  state_t              state_nxt_s;
  logic                cmp_s;
  logic                sample_s;
  logic                count_en_s;
  logic                publish_s;
  logic                en_rise_s;
  logic [CNT_W-1:0]    total_s;
  logic [OSR_LOG2-1:0] win_r;
  logic [CNT_W-1:0]    ones_r;
  logic [CNT_W-1:0]    result_r;
  logic                valid_r;
  logic                overrun_r;
  logic                fb_r;
  logic                en_d_r;

  sync2 u_sync2 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cmp_in),
    .q     (cmp_s)
  );

`ifdef OTA_SD_CHOP_EN
  logic             chop_r;
  logic [CNT_W-1:0] prev_r;

  // Chopper phase flips once per window; the previous window count is kept
  // so the published result spans both chopper phases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chop_r <= 1'b0;
      prev_r <= '0;
    end else if (publish_s) begin
      chop_r <= ~chop_r;
      prev_r <= ones_r;
    end else begin
      chop_r <= chop_r;
      prev_r <= prev_r;
    end
  end

  assign sample_s = cmp_s ^ chop_r;
  assign total_s  = sat_add(prev_r, ones_r);
  assign chop_out = chop_r;
`else
  assign sample_s = cmp_s;
  assign total_s  = ones_r;
  assign chop_out = 1'b0;
`endif

  assign en_rise_s = en & ~en_d_r;

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: dropping en aborts a window at any point.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (en) state_nxt_s = RUN;
        else    state_nxt_s = IDLE;
      end
      RUN: begin
        if (!en)                   state_nxt_s = IDLE;
        else if (win_r == WIN_LAST) state_nxt_s = DONE;
        else                       state_nxt_s = RUN;
      end
      DONE: begin
        if (en) state_nxt_s = RUN;
        else    state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Controller outputs: count only while running and enabled, publish in DONE.
  always_comb begin
    count_en_s = 1'b0;
    publish_s  = 1'b0;
    case (state_r)
      IDLE: begin
        count_en_s = 1'b0;
        publish_s  = 1'b0;
      end
      RUN: begin
        count_en_s = en;
        publish_s  = 1'b0;
      end
      DONE: begin
        count_en_s = 1'b0;
        publish_s  = 1'b1;
      end
      default: begin
        count_en_s = 1'b0;
        publish_s  = 1'b0;
      end
    endcase
  end

  // Window and ones counters; any non-counting cycle (IDLE, DONE, abort) clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_r  <= '0;
      ones_r <= '0;
    end else if (count_en_s) begin
      win_r  <= win_r + WIN_ONE;
      ones_r <= sat_add(ones_r, {{(CNT_W-1){1'b0}}, sample_s});
    end else begin
      win_r  <= '0;
      ones_r <= '0;
    end
  end

  // Result handshake: a new result always loads; valid drops only when accepted
  // and no new result arrives in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r <= '0;
      valid_r  <= 1'b0;
    end else if (publish_s) begin
      result_r <= total_s;
      valid_r  <= 1'b1;
    end else if (valid_r && result_ready) begin
      result_r <= result_r;
      valid_r  <= 1'b0;
    end else begin
      result_r <= result_r;
      valid_r  <= valid_r;
    end
  end

  // Sticky overrun: set when a pending result is overwritten, cleared on en rising.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_r <= 1'b0;
    end else if (en_rise_s) begin
      overrun_r <= 1'b0;
    end else if (publish_s && valid_r && !result_ready) begin
      overrun_r <= 1'b1;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  // Feedback DAC bit and enable history for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_r   <= 1'b0;
      en_d_r <= 1'b0;
    end else begin
      fb_r   <= en ? cmp_s : 1'b0;
      en_d_r <= en;
    end
  end

  assign fb_out       = fb_r;
  assign result       = result_r;
  assign result_valid = valid_r;
  assign overrun      = overrun_r;

endmodule
